abus_owner: RTL and testbench

//  Registered bus-ownership stage downstream of the lower-first arbiter abus_lf.
//  - Forwards master requests to the arbiter and latches the arbiter's one-hot result.
//  - Holds ownership until the owner drops its request, then inserts one dead cycle.
//  - Drives the registered grant/owner select used by the bus mux and slave side.

---
 rtl/abus_pkg.sv | 25 ++
 rtl/abus_owner.sv | 110 +++++++++++
 tb/tb_abus_owner.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/abus_pkg.sv
// Shared types and helpers for the abus ownership stage.
// Build option: ABUS_OWNER_TIMEOUT_EN enables forced release in abus_owner.
package abus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } abus_owner_state_t;

  localparam int ABUS_N     = 8;
  localparam int ABUS_IDX_W = $clog2(ABUS_N);
  localparam int ABUS_MAX_N = 64;

  // OR of the set bit positions; exact for one-hot input.
  function automatic logic [5:0] onehot2idx(input logic [ABUS_MAX_N-1:0] vec);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < ABUS_MAX_N; i++) begin
      if (vec[i]) idx = idx | 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/abus_owner.sv
// Registered bus-ownership stage behind the lower-first arbiter abus_lf.
// Build option: define ABUS_OWNER_TIMEOUT_EN to bound ownership at HOLD_MAX cycles.
//
//  state | meaning
//  IDLE  | no owner, waiting for a one-hot arbiter result
//  BUSY  | grant held while the owner keeps its request
//  GAP   | single dead cycle after a release, grant = 0
module abus_owner
  import abus_pkg::*;
#(
  parameter int N        = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         arb_req,
  input  logic [N-1:0]         arb_grant,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] owner_idx,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = $clog2(N);

  if (N < 2 || N > ABUS_MAX_N) begin : g_bad_n
    $error("abus_owner: N out of range");
  end
  if (HOLD_MAX < 2) begin : g_bad_hold
    $error("abus_owner: HOLD_MAX must be at least 2");
  end

  abus_owner_state_t state;
  logic [N-1:0]      mask;
  logic [N-1:0]      hit;
  logic [IW-1:0]     idx_next;
  logic              owner_req;
  logic              latch;
  logic              force_rel;

  assign arb_req   = req & ~mask;
  assign hit       = arb_grant & arb_req;
  assign idx_next  = IW'(onehot2idx(ABUS_MAX_N'(hit)));
  assign owner_req = req[owner_idx];
  // Only a clean one-hot result is trusted; anything else waits a cycle.
  assign latch     = (state != BUSY) && $onehot(hit);

`ifdef ABUS_OWNER_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] hold_cnt;

  assign force_rel = (state == BUSY) && owner_req && (hold_cnt == CW'(HOLD_MAX - 1));

  // A preempted master stays masked until it drops its request once.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      hold_cnt <= '0;
      mask     <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= force_rel;
      mask    <= (mask & req) | (force_rel ? (N'(1) << owner_idx) : '0);
      if (latch)
        hold_cnt <= '0;
      else if (state == BUSY && hold_cnt != CW'(HOLD_MAX - 1))
        hold_cnt <= hold_cnt + CW'(1);
    end
  end
`else
  assign force_rel = 1'b0;
  assign mask      = '0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state     <= IDLE;
      grant     <= '0;
      owner_idx <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (latch) begin
            state     <= BUSY;
            grant     <= hit;
            owner_idx <= idx_next;
            busy      <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (!owner_req || force_rel) begin
            state <= GAP;
            grant <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_abus_owner.sv
// Self-checking bench for abus_owner with a behavioural lower-first arbiter in the loop.
// Expectations follow ABUS_OWNER_TIMEOUT_EN when it is defined for the build.
module tb_abus_owner;

  localparam int N        = 8;
  localparam int HOLD_MAX = 4;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] arb_req;
  logic [N-1:0] arb_grant;
  logic [N-1:0] grant;
  logic [2:0]   owner_idx;
  logic         busy;
  logic         timeout;

  logic         force_en = 1'b0;
  logic [N-1:0] force_val = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference state: current owner (-1 = none), last owner index, BUSY cycles, mask
  int           m_owner = -1;
  int           m_last  = 0;
  int           m_hold  = 0;
  logic [N-1:0] m_mask  = '0;
  bit           m_to    = 1'b0;

  always #5 clk = ~clk;

  abus_owner #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .req       (req),
    .arb_req   (arb_req),
    .arb_grant (arb_grant),
    .grant     (grant),
    .owner_idx (owner_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  // lower-first arbiter stand-in, overridable for the bad-grant case
  always_comb begin
    arb_grant = '0;
    if (force_en) arb_grant = force_val;
    else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (arb_req[i]) arb_grant = N'(1) << i;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] r, ar, ag, hit, newmask, exp_grant;
    bit rb;
    r  = req;
    rb = rstb;
    ar = r & ~m_mask;
    ag = force_en ? force_val : (ar & (~ar + N'(1)));
    hit = ag & ar;
    @(posedge clk);
    #1;
    m_to = 1'b0;
    if (!rb) begin
      m_owner = -1;
      m_last  = 0;
      m_hold  = 0;
      m_mask  = '0;
    end else begin
      newmask = m_mask & r;
      if (m_owner >= 0) begin
        if (!r[m_owner]) m_owner = -1;
`ifdef ABUS_OWNER_TIMEOUT_EN
        else if (m_hold == HOLD_MAX - 1) begin
          newmask[m_owner] = 1'b1;
          m_owner = -1;
          m_to = 1'b1;
        end else m_hold++;
`endif
      end else if ($countones(hit) == 1) begin
        for (int i = 0; i < N; i++) if (hit[i]) m_owner = i;
        m_last = m_owner;
        m_hold = 0;
      end
      m_mask = newmask;
    end
    exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check("grant", 32'(grant), 32'(exp_grant));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("owner_idx", 32'(owner_idx), 32'(m_last));
    check("timeout", 32'(timeout), 32'(m_to));
    check("arb_req", 32'(arb_req), 32'(req & ~m_mask));
    check("grant_onehot0", 32'($countones(grant) <= 1), 32'd1);
    check("busy_vs_grant", 32'(busy), 32'(|grant));
  endtask

  initial begin
    // 1: reset with all requesting, then lowest master wins
    rstb = 1'b0; req = 8'hFF;
    repeat (3) step();
    check("t1_reset_grant", 32'(grant), 32'h0);
    rstb = 1'b1;
    step();
    check("t1_first_grant", 32'(grant), 32'h01);

    // 2: handover 2 -> 3 with one dead cycle
    req = 8'h0C;
    step();
    step();
    check("t2_grant4", 32'(grant), 32'h04);
    req = 8'h08;
    step();
    check("t2_gap", 32'(grant), 32'h0);
    step();
    check("t2_grant8", 32'(grant), 32'h08);
    check("t2_idx3", 32'(owner_idx), 32'd3);

    // 3: release into idle
    req = 8'h00;
    repeat (5) step();
    check("t3_idle", 32'(busy), 32'd0);

    // 4: non-one-hot arbiter result is ignored
    force_en = 1'b1; force_val = 8'h03; req = 8'h03;
    repeat (3) step();
    check("t4_ignored", 32'(grant), 32'h0);
    force_en = 1'b0;
    step();
    check("t4_restored", 32'(grant), 32'h01);

    // 5: long hold
    req = 8'h00;
    repeat (2) step();
    req = 8'h01;
    step();
    check("t5_latch", 32'(grant), 32'h01);
    repeat (3) step();
    check("t5_held", 32'(grant), 32'h01);
    step();
`ifdef ABUS_OWNER_TIMEOUT_EN
    check("t5_timeout", 32'(timeout), 32'd1);
    check("t5_masked", 32'(arb_req), 32'h0);
`else
    check("t5_unbounded", 32'(grant), 32'h01);
`endif
    step();
    req = 8'h03;
    step();
`ifdef ABUS_OWNER_TIMEOUT_EN
    check("t5_next_owner", 32'(grant), 32'h02);
`else
    check("t5_still_owner", 32'(grant), 32'h01);
`endif
    repeat (6) step();
    req = 8'h00;
    repeat (3) step();

    // 6: reset during ownership
    req = 8'h10;
    step();
    check("t6_grant", 32'(grant), 32'h10);
    step();
    rstb = 1'b0;
    step();
    check("t6_reset_drop", 32'(grant), 32'h0);
    rstb = 1'b1;
    step();
    check("t6_regrant", 32'(grant), 32'h10);

    // random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if ($urandom_range(3) == 0) req[i] = 1'b0;
        end else if ($urandom_range(2) == 0) req[i] = 1'b1;
      end
      force_en  = ($urandom_range(19) == 0);
      force_val = N'($urandom);
      rstb      = ($urandom_range(99) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
